// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: takes decoded note-on/note-off events and maps
// them onto NUM_VOICES synth voices. Each event is handled by a serial scan of
// the voices (one per cycle), followed by a single apply step. When all voices
// are busy the least-recently-allocated voice is stolen and its gate is held
// low for RETRIG_CYCLES so the envelope restarts cleanly.
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int VOICE_BITS    = 2,
  parameter int RETRIG_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_note_on,
  input  logic [6:0]              in_note,
  input  logic [6:0]              in_velocity,
  input  logic                    panic,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_velocity,
  output logic                    steal_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_APPLY,
    S_RETRIG
  } state_t;

  localparam int CNT_BITS = (RETRIG_CYCLES > 1) ? $clog2(RETRIG_CYCLES) : 1;

  localparam logic [VOICE_BITS-1:0] LAST_IDX    = VOICE_BITS'(NUM_VOICES - 1);
  localparam logic [VOICE_BITS-1:0] OLDEST_RANK = VOICE_BITS'(NUM_VOICES - 1);
  localparam logic [VOICE_BITS-1:0] IDX_ONE     = VOICE_BITS'(1);
  localparam logic [CNT_BITS-1:0]   CNT_MAX     = CNT_BITS'(RETRIG_CYCLES - 1);
  localparam logic [CNT_BITS-1:0]   CNT_ONE     = CNT_BITS'(1);

  state_t state;
  state_t state_next;

  // Per-voice state. rank 0 = most recently allocated, NUM_VOICES-1 = oldest.
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [VOICE_BITS-1:0] rank_q [NUM_VOICES];

  // Event being processed, latched at acceptance.
  logic                  ev_on;
  logic [6:0]            ev_note;
  logic [6:0]            ev_vel;

  // Scan progress and the candidates it collects.
  logic [VOICE_BITS-1:0] scan_idx;
  logic                  free_found;
  logic [VOICE_BITS-1:0] free_idx;
  logic                  match_found;
  logic [VOICE_BITS-1:0] match_idx;
  logic [VOICE_BITS-1:0] oldest_idx;

  // Retrigger bookkeeping.
  logic [VOICE_BITS-1:0] retrig_idx;
  logic [CNT_BITS-1:0]   retrig_cnt;

  // Apply-step decision, derived from the scan results.
  logic [VOICE_BITS-1:0] target_idx;
  logic [VOICE_BITS-1:0] target_rank;
  logic                  is_restrike;
  logic                  is_alloc;
  logic                  is_steal;

  logic accept;

  // Panic blocks acceptance in the same cycle so the event cannot sneak in.
  assign in_ready = (state == S_IDLE) && !panic;
  assign accept   = in_valid && in_ready;

  // Choose the voice the current event acts on: a matching voice wins, then a
  // free voice, and only then the oldest voice is stolen.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    target_idx  = match_idx;
    is_restrike = 1'b0;
    is_alloc    = 1'b0;
    is_steal    = 1'b0;
    if (ev_on) begin
      if (match_found) begin
        target_idx  = match_idx;
        is_restrike = 1'b1;
      end else if (free_found) begin
        target_idx  = free_idx;
        is_alloc    = 1'b1;
      end else begin
        target_idx  = oldest_idx;
        is_steal    = 1'b1;
      end
    end
  end

  assign target_rank = rank_q[target_idx];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples the pre-edge values of the others.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; panic overrides every transition.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_idx == LAST_IDX) begin
          state_next = S_APPLY;
        end
      end
      S_APPLY: begin
        if (is_restrike || is_steal) begin
          state_next = S_RETRIG;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RETRIG: begin
        if (retrig_cnt == CNT_MAX) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (panic) begin
      state_next = S_IDLE;
    end
  end

  // Event latch, voice scan, apply step, retrigger counter and voice state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the voice arrays are reset, not left uninitialised: their values
      // drive the voice outputs directly and must read as zero after reset.
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        rank_q[i] <= VOICE_BITS'(i);
      end
      voice_gate  <= '0;
      steal_pulse <= 1'b0;
      ev_on       <= 1'b0;
      ev_note     <= '0;
      ev_vel      <= '0;
      scan_idx    <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      oldest_idx  <= '0;
      retrig_idx  <= '0;
      retrig_cnt  <= '0;
    end else if (panic) begin
      // All notes off; notes, velocities and ranks are deliberately kept.
      voice_gate  <= '0;
      steal_pulse <= 1'b0;
    end else begin
      steal_pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            // A note-on with velocity 0 is a note-off by MIDI convention.
            ev_on       <= in_note_on && (in_velocity != 7'd0);
            ev_note     <= in_note;
            ev_vel      <= in_velocity;
            scan_idx    <= '0;
            free_found  <= 1'b0;
            match_found <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!voice_gate[scan_idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (voice_gate[scan_idx] && (note_q[scan_idx] == ev_note) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (rank_q[scan_idx] == OLDEST_RANK) begin
            oldest_idx <= scan_idx;
          end
          scan_idx <= scan_idx + IDX_ONE;
        end
        S_APPLY: begin
          if (!ev_on) begin
            if (match_found) begin
              voice_gate[match_idx] <= 1'b0;
            end
          end else begin
            // Rank update: target becomes newest, younger voices age by one.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (VOICE_BITS'(i) == target_idx) begin
                rank_q[i] <= '0;
              end else if (rank_q[i] < target_rank) begin
                rank_q[i] <= rank_q[i] + IDX_ONE;
              end
            end
            vel_q[target_idx] <= ev_vel;
            if (is_alloc) begin
              note_q[target_idx]     <= ev_note;
              voice_gate[target_idx] <= 1'b1;
            end else begin
              // Re-strike or steal: gate drops, RETRIG raises it again later.
              if (is_steal) begin
                note_q[target_idx] <= ev_note;
                steal_pulse        <= 1'b1;
              end
              voice_gate[target_idx] <= 1'b0;
              retrig_idx             <= target_idx;
              retrig_cnt             <= '0;
            end
          end
        end
        S_RETRIG: begin
          if (retrig_cnt == CNT_MAX) begin
            voice_gate[retrig_idx] <= 1'b1;
          end else begin
            retrig_cnt <= retrig_cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Pack per-voice notes and velocities; voice i sits at bits [7i+6:7i].
  always_comb begin
    voice_note     = '0;
    voice_velocity = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7]     = note_q[i];
      voice_velocity[7*i +: 7] = vel_q[i];
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (4 voices, 4-cycle retrigger gap).
// Expected voice states are queued when an event is driven and compared when
// the allocator is due to show the result.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_note_on = 1'b0;
  logic [6:0]    in_note = '0;
  logic [6:0]    in_velocity = '0;
  logic          panic = 1'b0;
  logic [NV-1:0] voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_velocity;
  logic          steal_pulse;

  voice_allocator #(
    .NUM_VOICES   (NV),
    .VOICE_BITS   (2),
    .RETRIG_CYCLES(RC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_note_on    (in_note_on),
    .in_note       (in_note),
    .in_velocity   (in_velocity),
    .panic         (panic),
    .voice_gate    (voice_gate),
    .voice_note    (voice_note),
    .voice_velocity(voice_velocity),
    .steal_pulse   (steal_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NV-1:0]   gate;
    logic [7*NV-1:0] note;
    logic [7*NV-1:0] vel;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   steal_cnt = 0;

  always @(posedge clk) begin
    if (steal_pulse === 1'b1) steal_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [27:0] pack4(input logic [6:0] a3, input logic [6:0] a2,
                                        input logic [6:0] a1, input logic [6:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic push(input logic [NV-1:0] g, input logic [27:0] n, input logic [27:0] v);
    exp_t e;
    e.gate = g;
    e.note = n;
    e.vel  = v;
    exp_q.push_back(e);
  endtask

  // Pops the next expectation and compares all voice outputs; returns its gate.
  task automatic check_state(input string tag, output logic [NV-1:0] g);
    exp_t e;
    g = '0;
    tests++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = e.gate;
      check({tag, "_gate"}, 32'(voice_gate), 32'(e.gate));
      check({tag, "_note"}, 32'(voice_note), 32'(e.note));
      check({tag, "_vel"},  32'(voice_velocity), 32'(e.vel));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    panic = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers one event and returns at the falling edge of cycle T+1.
  task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v);
    int guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_send", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_note_on  = on;
    in_note     = n;
    in_velocity = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Allocate / note-off path: result and in_ready appear at T+6.
  task automatic finish_plain(input string tag);
    logic [NV-1:0] g;
    repeat (4) @(negedge clk);
    check({tag, "_busy_t5"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check_state(tag, g);
    check({tag, "_ready_t6"}, 32'(in_ready), 32'd1);
  endtask

  // Re-strike / steal path: gate low from T+6 to T+9, high again at T+10.
  task automatic finish_retrig(input string tag, input logic steal_exp);
    logic [NV-1:0] g_low;
    logic [NV-1:0] g_high;
    int            steal_before;
    steal_before = steal_cnt;
    repeat (4) @(negedge clk);
    check({tag, "_busy_t5"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check_state({tag, "_low"}, g_low);
    check({tag, "_steal_t6"}, 32'(steal_pulse), 32'(steal_exp));
    @(negedge clk);
    check({tag, "_steal_t7"}, 32'(steal_pulse), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_gate_t9"}, 32'(voice_gate), 32'(g_low));
    check({tag, "_busy_t9"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check_state({tag, "_high"}, g_high);
    check({tag, "_ready_t10"}, 32'(in_ready), 32'd1);
    check({tag, "_steal_count"}, 32'(steal_cnt - steal_before), 32'(steal_exp));
  endtask

  task automatic check_reset_state(input string tag);
    logic [NV-1:0] g;
    push('0, '0, '0);
    check_state(tag, g);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_steal"}, 32'(steal_pulse), 32'd0);
  endtask

  // Allocates base..base+3 into voices 0..3, all with velocity vel.
  task automatic fill_four(input logic [6:0] base, input logic [6:0] vel);
    logic [27:0] n_acc = '0;
    logic [27:0] v_acc = '0;
    logic [NV-1:0] g_acc = '0;
    for (int i = 0; i < NV; i++) begin
      n_acc[7*i +: 7] = base + 7'(i);
      v_acc[7*i +: 7] = vel;
      g_acc[i] = 1'b1;
      push(g_acc, n_acc, v_acc);
      send(1'b1, base + 7'(i), vel);
      finish_plain($sformatf("fill_%0d", i));
    end
  endtask

  initial begin
    logic [NV-1:0] g;

    // Reset and first allocation.
    do_reset();
    check_reset_state("reset");
    push(4'b0001, pack4(0, 0, 0, 60), pack4(0, 0, 0, 100));
    send(1'b1, 7'd60, 7'd100);
    finish_plain("alloc_v0");

    // Fill the rest, free voice 1, reuse it.
    push(4'b0011, pack4(0, 0, 62, 60), pack4(0, 0, 90, 100));
    send(1'b1, 7'd62, 7'd90);
    finish_plain("alloc_v1");
    push(4'b0111, pack4(0, 64, 62, 60), pack4(0, 80, 90, 100));
    send(1'b1, 7'd64, 7'd80);
    finish_plain("alloc_v2");
    push(4'b1111, pack4(65, 64, 62, 60), pack4(70, 80, 90, 100));
    send(1'b1, 7'd65, 7'd70);
    finish_plain("alloc_v3");
    push(4'b1101, pack4(65, 64, 62, 60), pack4(70, 80, 90, 100));
    send(1'b0, 7'd62, 7'd0);
    finish_plain("noteoff_62");
    push(4'b1111, pack4(65, 64, 67, 60), pack4(70, 80, 50, 100));
    send(1'b1, 7'd67, 7'd50);
    finish_plain("realloc_v1");

    // Ranks now oldest-first: v0, v2, v3, v1. Steal v0, then v2.
    push(4'b1110, pack4(65, 64, 67, 70), pack4(70, 80, 50, 33));
    push(4'b1111, pack4(65, 64, 67, 70), pack4(70, 80, 50, 33));
    send(1'b1, 7'd70, 7'd33);
    finish_retrig("steal_v0_ranked", 1'b1);
    push(4'b1011, pack4(65, 72, 67, 70), pack4(70, 20, 50, 33));
    push(4'b1111, pack4(65, 72, 67, 70), pack4(70, 20, 50, 33));
    send(1'b1, 7'd72, 7'd20);
    finish_retrig("steal_v2_ranked", 1'b1);

    // Five note-ons from reset: fifth steals voice 0.
    do_reset();
    check_reset_state("reset2");
    fill_four(7'd60, 7'd100);
    push(4'b1110, pack4(63, 62, 61, 64), pack4(100, 100, 100, 110));
    push(4'b1111, pack4(63, 62, 61, 64), pack4(100, 100, 100, 110));
    send(1'b1, 7'd64, 7'd110);
    finish_retrig("steal_fifth", 1'b1);

    // Velocity-0 note-on acts as note-off; unmatched note-off changes nothing.
    do_reset();
    push(4'b0001, pack4(0, 0, 0, 60), pack4(0, 0, 0, 100));
    send(1'b1, 7'd60, 7'd100);
    finish_plain("vel0_setup");
    push(4'b0000, pack4(0, 0, 0, 60), pack4(0, 0, 0, 100));
    send(1'b1, 7'd60, 7'd0);
    finish_plain("vel0_noteoff");
    push(4'b0000, pack4(0, 0, 0, 60), pack4(0, 0, 0, 100));
    send(1'b0, 7'd99, 7'd5);
    finish_plain("noteoff_nomatch");

    // Re-strike reuses voice 0 without stealing.
    do_reset();
    push(4'b0001, pack4(0, 0, 0, 60), pack4(0, 0, 0, 100));
    send(1'b1, 7'd60, 7'd100);
    finish_plain("restrike_setup");
    push(4'b0000, pack4(0, 0, 0, 60), pack4(0, 0, 0, 40));
    push(4'b0001, pack4(0, 0, 0, 60), pack4(0, 0, 0, 40));
    send(1'b1, 7'd60, 7'd40);
    finish_retrig("restrike", 1'b0);
    push(4'b0011, pack4(0, 0, 61, 60), pack4(0, 0, 10, 40));
    send(1'b1, 7'd61, 7'd10);
    finish_plain("after_restrike");

    // Panic mid-scan with all voices gated.
    do_reset();
    fill_four(7'd60, 7'd100);
    send(1'b1, 7'd70, 7'd33);
    @(negedge clk);
    panic = 1'b1;
    @(negedge clk);
    check("panic_gates", 32'(voice_gate), 32'd0);
    check("panic_ready_forced", 32'(in_ready), 32'd0);
    panic = 1'b0;
    #1;
    check("panic_ready_after", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    push(4'b0000, pack4(63, 62, 61, 60), pack4(100, 100, 100, 100));
    check_state("panic_discard", g);

    // Event offered together with panic is not taken.
    @(negedge clk);
    in_valid = 1'b1;
    in_note_on = 1'b1;
    in_note = 7'd90;
    in_velocity = 7'd90;
    panic = 1'b1;
    #1;
    check("panic_idle_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    panic = 1'b0;
    repeat (8) @(negedge clk);
    push(4'b0000, pack4(63, 62, 61, 60), pack4(100, 100, 100, 100));
    check_state("panic_no_accept", g);
    push(4'b0001, pack4(63, 62, 61, 80), pack4(100, 100, 100, 5));
    send(1'b1, 7'd80, 7'd5);
    finish_plain("after_panic_alloc");

    // Reset in the middle of a scan discards everything.
    send(1'b1, 7'd50, 7'd50);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midop_reset");
    repeat (8) @(negedge clk);
    check_reset_state("midop_reset_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI byte decoder and the bank of tiny-synth voices inside the MIDI player.
- Accepts decoded note-on and note-off events and assigns each to one of NUM_VOICES voices. Drives each voice's gate, note and velocity.
- When every voice is busy, it steals the least-recently-allocated voice and forces a gate retrigger gap so the envelope restarts.

Parameters:
- NUM_VOICES, 4: number of voice slots (2..16).
- VOICE_BITS, 2: width of a voice index/rank; must be >= clog2(NUM_VOICES).
- RETRIG_CYCLES, 16: cycles a stolen or re-struck voice holds gate low before re-asserting (>= 1).

Ports:
- clk  in  1  system clock, the 16MHz synth clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  event present.
- in_ready  out  1  allocator can accept an event this cycle.
- in_note_on  in  1  1 = note-on, 0 = note-off.
- in_note  in  7  MIDI note number.
- in_velocity  in  7  MIDI velocity.
- panic  in  1  all-notes-off request.
- voice_gate  out  NUM_VOICES  per-voice gate.
- voice_note  out  7*NUM_VOICES  packed notes; voice i occupies bits [7i+6:7i].
- voice_velocity  out  7*NUM_VOICES  packed velocities, same packing.
- steal_pulse  out  1  one-cycle strobe when a voice is stolen.

Behaviour:
- Reset:
  - voice_gate=0, voice_note=0, voice_velocity=0, steal_pulse=0.
  - Age rank of voice i = i. State=IDLE, in_ready=1.
- Handshake: an event is accepted in cycle T when in_valid & in_ready. Fields are latched at T. in_ready = (state==IDLE), so it drops at T+1.
- Normalisation: a note-on with velocity 0 is treated as a note-off.
- States:
  - IDLE: waits for an accepted event, then goes to SCAN.
  - SCAN: visits one voice per cycle, index 0..NUM_VOICES-1, over NUM_VOICES cycles. It records three candidates:
    - first free voice: lowest index with gate=0;
    - first matching voice: lowest index with gate=1 and note==event note;
    - oldest voice: rank NUM_VOICES-1.
  - After the last voice, SCAN goes to APPLY.
  - APPLY, note-off, match found: clear that gate, then go to IDLE.
  - APPLY, note-off, no match: no change, then go to IDLE.
  - APPLY, note-on, match found (re-strike): load the velocity, clear the gate, then go to RETRIG.
  - APPLY, note-on, free voice found: load note and velocity, set the gate, update ranks, then go to IDLE.
  - APPLY, note-on, otherwise (steal): load note and velocity into the oldest voice, clear its gate, pulse steal_pulse, update ranks, then go to RETRIG.
  - RETRIG: counts RETRIG_CYCLES cycles with the gate low, then sets the target gate and goes to IDLE.
- Rank update on every note-on allocation, including re-strike. The target's rank becomes 0. Every voice whose rank was lower than the target's old rank increments by 1. Ranks always remain a permutation of 0..NUM_VOICES-1.
- Latency, accepted at T:
  - Outputs reflect APPLY at T+NUM_VOICES+2.
  - in_ready is back high at T+NUM_VOICES+2 for the plain allocate and note-off paths.
  - For retrigger paths the gate rises and in_ready returns at T+NUM_VOICES+2+RETRIG_CYCLES.
- panic (any state, any cycle) takes priority over everything except rst:
  - Next cycle all gates are 0, any in-flight event is discarded, and state returns to IDLE.
  - Notes, velocities and ranks are kept.
  - An event offered in the same cycle as panic is not accepted (in_ready is forced 0 while panic is high).
- The outputs of non-target voices never change during event processing.
- rst mid-operation returns all state to reset values on the next edge.

Test Plan (NUM_VOICES=4, RETRIG_CYCLES=4):
- Reset, then note-on 60/100 accepted at T -> voice 0 gate=1, note=60, velocity=100 at T+6; in_ready high at T+6; other voices are unchanged.
- Note-on 60, 62, 64, 65, then note-off 62 -> voices 0..3 hold 60/62/64/65; voice1 gate drops, the rest stay 1; a following note-on 67 lands in voice 1.
- Five note-ons 60..64 with no note-offs -> the fifth steals voice 0: steal_pulse for one cycle, voice0 gate low for 4 cycles, then high with note=64.
- Note-on 60 vel 100, then note-on 60 vel 0 -> treated as note-off: voice0 gate=0, no allocation.
- Re-strike: note-on 60 twice -> the second reuses voice 0: gate low 4 cycles then high, velocity updated, no steal_pulse.
- panic asserted mid-SCAN with all 4 voices gated -> all gates 0 next cycle, in_ready=1 the cycle after panic deasserts, and the scanned event causes no change.
